// File: rtl/sm83_irq_ctl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sm83_irq_ctl : IF/IE interrupt flag/enable registers feeding the sm83     |
// |   core; optional level capture via SM83_IRQ_LEVEL_EN.  Rev 1.0            |
// +--------------------------------------------------------------------------+
module sm83_irq_ctl #(
  parameter int          WORD_SIZE = 8,
  parameter int          NUM_IRQS  = 5,
  parameter logic [15:0] IF_ADR    = 16'hff0f,
  parameter logic [15:0] IE_ADR    = 16'hffff
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [NUM_IRQS-1:0]  req_i,
  input  logic [15:0]          adr_i,
  input  logic [WORD_SIZE-1:0] din_i,
  input  logic                 wr_i,
  input  logic                 rd_i,
  output logic [WORD_SIZE-1:0] dout_o,
  output logic                 dout_oe_o,
  output logic [WORD_SIZE-1:0] irq_o,
  input  logic [WORD_SIZE-1:0] iack_i,
  output logic                 pending_o
);

  logic [NUM_IRQS-1:0]  if_q, if_d, set_req;
  logic [WORD_SIZE-1:0] ie_q, ie_d;
  logic [WORD_SIZE-1:0] dout_q, dout_d, if_rdval;
  logic                 dout_oe_q, dout_oe_d;
  logic                 sel_if, sel_ie, wr_if, wr_ie;

  assign sel_if = (adr_i == IF_ADR);
  assign sel_ie = (adr_i == IE_ADR);
  assign wr_if  = wr_i & sel_if;
  assign wr_ie  = wr_i & sel_ie;

`ifdef SM83_IRQ_LEVEL_EN
  assign set_req = req_i;
`else
  // A held line only flags once; it must drop before it can request again.
  logic [NUM_IRQS-1:0] req_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) req_q <= '0;
    else         req_q <= req_i;
  end

  assign set_req = req_i & ~req_q;
`endif

  generate
    if (NUM_IRQS < WORD_SIZE) begin : g_unused_iack
      logic unused_iack_hi;
      assign unused_iack_hi = ^iack_i[WORD_SIZE-1:NUM_IRQS];
    end
  endgenerate

  always_comb begin
    if_rdval                 = '1;
    if_rdval[NUM_IRQS-1:0]   = if_q;
    irq_o                    = '0;
    irq_o[NUM_IRQS-1:0]      = if_q & ie_q[NUM_IRQS-1:0];
    pending_o                = |irq_o;

    // New request edge beats acknowledge, which beats a CPU write.
    if_d = ((wr_if ? din_i[NUM_IRQS-1:0] : if_q) & ~iack_i[NUM_IRQS-1:0]) | set_req;
    ie_d = wr_ie ? din_i : ie_q;

    dout_d    = dout_q;
    dout_oe_d = 1'b0;
    if (rd_i && (sel_if || sel_ie)) begin
      dout_oe_d = 1'b1;
      dout_d    = sel_if ? if_rdval : ie_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      if_q      <= '0;
      ie_q      <= '0;
      dout_q    <= '0;
      dout_oe_q <= 1'b0;
    end else begin
      if_q      <= if_d;
      ie_q      <= ie_d;
      dout_q    <= dout_d;
      dout_oe_q <= dout_oe_d;
    end
  end

  assign dout_o    = dout_q;
  assign dout_oe_o = dout_oe_q;

endmodule
`default_nettype wire

// File: tb/tb_sm83_irq_ctl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sm83_irq_ctl : vector table, corner sequences and random stimulus      |
// |   against a byte-level model of the IF/IE registers.  Rev 1.0             |
// +--------------------------------------------------------------------------+
module tb_sm83_irq_ctl;

  localparam logic [15:0] IFA = 16'hff0f;
  localparam logic [15:0] IEA = 16'hffff;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  req;
  logic [15:0] adr;
  logic [7:0]  din;
  logic        wr, rd;
  logic [7:0]  dout;
  logic        dout_oe;
  logic [7:0]  irq;
  logic [7:0]  iack;
  logic        pending;

  always #5 clk = ~clk;

  sm83_irq_ctl dut (
    .clk_i     (clk),
    .reset_i   (reset),
    .req_i     (req),
    .adr_i     (adr),
    .din_i     (din),
    .wr_i      (wr),
    .rd_i      (rd),
    .dout_o    (dout),
    .dout_oe_o (dout_oe),
    .irq_o     (irq),
    .iack_i    (iack),
    .pending_o (pending)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: whole registers as bytes, updated by the textual rules.
  logic [7:0] m_if, m_ie, m_dout, m_prev_req;
  logic       m_oe;

  typedef struct {
    logic [4:0]  req;
    logic [15:0] adr;
    logic [7:0]  din;
    logic        wr;
    logic        rd;
    logic [7:0]  iack;
    logic [7:0]  e_dout;
    logic        e_oe;
    logic [7:0]  e_irq;
  } vec_t;

  function automatic vec_t mk(logic [4:0] r, logic [15:0] a, logic [7:0] d, logic w, logic rr,
                              logic [7:0] k, logic [7:0] ed, logic eo, logic [7:0] ei);
    vec_t v;
    v.req = r; v.adr = a; v.din = d; v.wr = w; v.rd = rr; v.iack = k;
    v.e_dout = ed; v.e_oe = eo; v.e_irq = ei;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic [4:0] rq, input logic [15:0] a,
                            input logic [7:0] d, input logic w, input logic rdd, input logic [7:0] k);
    logic [7:0] nxt;
    logic [7:0] newreq;
    if (r) begin
      m_if = 0; m_ie = 0; m_dout = 0; m_oe = 0; m_prev_req = 0;
    end else begin
      if (rdd && (a == IFA || a == IEA)) begin
        m_dout = (a == IFA) ? (m_if | 8'he0) : m_ie;
        m_oe   = 1;
      end else begin
        m_oe = 0;
      end
      nxt = m_if;
      if (w && a == IFA) nxt = d & 8'h1f;
      nxt = nxt & ~k;
`ifdef SM83_IRQ_LEVEL_EN
      newreq = {3'b000, rq};
`else
      newreq = {3'b000, rq} & ~m_prev_req;
`endif
      nxt = (nxt | newreq) & 8'h1f;
      if (w && a == IEA) m_ie = d;
      m_prev_req = {3'b000, rq};
      m_if = nxt;
    end
  endtask

  // One clock: drive, clock, advance model, sample 1 ns after the edge.
  task automatic step(input logic r, input logic [4:0] rq, input logic [15:0] a,
                      input logic [7:0] d, input logic w, input logic rdd, input logic [7:0] k,
                      input bit cmp_model);
    reset = r; req = rq; adr = a; din = d; wr = w; rd = rdd; iack = k;
    @(posedge clk);
    model_edge(r, rq, a, d, w, rdd, k);
    #1;
    if (cmp_model) begin
      chk("irq", {8'h00, irq}, {8'h00, m_if & m_ie});
      chk("pending", {15'h0, pending}, {15'h0, (m_if & m_ie) != 0});
      chk("dout", {8'h00, dout}, {8'h00, m_dout});
      chk("dout_oe", {15'h0, dout_oe}, {15'h0, m_oe});
    end
  endtask

  vec_t tbl[22];

  initial begin
    reset = 1; req = 0; adr = 0; din = 0; wr = 0; rd = 0; iack = 0;
    m_if = 0; m_ie = 0; m_dout = 0; m_oe = 0; m_prev_req = 0;

    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("reset_irq", {8'h00, irq}, 16'h0000);
    chk("reset_pending", {15'h0, pending}, 16'h0000);
    chk("reset_dout", {8'h00, dout}, 16'h0000);
    chk("reset_oe", {15'h0, dout_oe}, 16'h0000);

`ifndef SM83_IRQ_LEVEL_EN
    //              req     adr      din    wr rd iack   dout   oe irq
    tbl[0]  = mk(5'h00, IEA,     8'h1f, 1, 0, 8'h00, 8'h00, 0, 8'h00);
    tbl[1]  = mk(5'h04, 16'h0,   8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h04);
    tbl[2]  = mk(5'h00, IFA,     8'h00, 0, 1, 8'h00, 8'he4, 1, 8'h04);
    tbl[3]  = mk(5'h00, 16'h0,   8'h00, 0, 0, 8'h00, 8'he4, 0, 8'h04);
    tbl[4]  = mk(5'h00, 16'h0,   8'h00, 0, 0, 8'h04, 8'he4, 0, 8'h00);
    tbl[5]  = mk(5'h03, IEA,     8'h03, 1, 0, 8'h00, 8'he4, 0, 8'h03);
    tbl[6]  = mk(5'h03, 16'h0,   8'h00, 0, 0, 8'h01, 8'he4, 0, 8'h02);
    tbl[7]  = mk(5'h03, 16'h0,   8'h00, 0, 0, 8'h00, 8'he4, 0, 8'h02);
    tbl[8]  = mk(5'h01, 16'h0,   8'h00, 0, 0, 8'h00, 8'he4, 0, 8'h02);
    tbl[9]  = mk(5'h03, IFA,     8'h00, 0, 1, 8'h02, 8'he2, 1, 8'h02);
    tbl[10] = mk(5'h00, IEA,     8'h1f, 1, 0, 8'h00, 8'he2, 0, 8'h02);
    tbl[11] = mk(5'h10, IFA,     8'h00, 1, 0, 8'h00, 8'he2, 0, 8'h10);
    tbl[12] = mk(5'h00, IFA,     8'h00, 0, 1, 8'h00, 8'hf0, 1, 8'h10);
    tbl[13] = mk(5'h00, IFA,     8'hff, 1, 1, 8'h00, 8'hf0, 1, 8'h1f);
    tbl[14] = mk(5'h00, IFA,     8'h00, 0, 1, 8'h00, 8'hff, 1, 8'h1f);
    tbl[15] = mk(5'h00, IEA,     8'ha5, 1, 0, 8'h00, 8'hff, 0, 8'h05);
    tbl[16] = mk(5'h00, IEA,     8'h00, 0, 1, 8'h00, 8'ha5, 1, 8'h05);
    tbl[17] = mk(5'h00, 16'hff10,8'h00, 0, 1, 8'h00, 8'ha5, 0, 8'h05);
    tbl[18] = mk(5'h00, 16'h0,   8'h00, 0, 0, 8'hff, 8'ha5, 0, 8'h00);
    tbl[19] = mk(5'h00, IFA,     8'he0, 1, 0, 8'h00, 8'ha5, 0, 8'h00);
    tbl[20] = mk(5'h00, IFA,     8'h00, 0, 1, 8'h00, 8'he0, 1, 8'h00);
    tbl[21] = mk(5'h00, IFA,     8'h04, 1, 0, 8'h00, 8'he0, 0, 8'h04);
    for (int i = 0; i < 22; i++) begin
      step(0, tbl[i].req, tbl[i].adr, tbl[i].din, tbl[i].wr, tbl[i].rd, tbl[i].iack, 0);
      chk($sformatf("vec%0d_irq", i), {8'h00, irq}, {8'h00, tbl[i].e_irq});
      chk($sformatf("vec%0d_pending", i), {15'h0, pending}, {15'h0, tbl[i].e_irq != 0});
      chk($sformatf("vec%0d_dout", i), {8'h00, dout}, {8'h00, tbl[i].e_dout});
      chk($sformatf("vec%0d_oe", i), {15'h0, dout_oe}, {15'h0, tbl[i].e_oe});
    end
`endif

    // Held request against acknowledge: edge mode clears, level mode re-sets.
    step(1, 0, 0, 0, 0, 0, 0, 1);
    step(0, 5'h01, IEA, 8'hff, 1, 0, 8'h00, 1);
    step(0, 5'h01, 16'h0, 8'h00, 0, 0, 8'h01, 1);
`ifdef SM83_IRQ_LEVEL_EN
    chk("held_iack_irq", {8'h00, irq}, 16'h0001);
`else
    chk("held_iack_irq", {8'h00, irq}, 16'h0000);
`endif
    // Reset mid-request, then the held line counts as a fresh edge.
    step(1, 5'h01, IFA, 8'h00, 0, 1, 8'h00, 1);
    chk("midreset_irq", {8'h00, irq}, 16'h0000);
    chk("midreset_oe", {15'h0, dout_oe}, 16'h0000);
    step(0, 5'h01, 16'h0, 8'h00, 0, 0, 8'h00, 1);
    step(0, 5'h01, IFA, 8'h00, 0, 1, 8'h00, 1);
    chk("post_reset_if", {8'h00, dout}, 16'h00e1);

    for (int n = 0; n < 600; n++) begin
      logic [15:0] a;
      logic [7:0]  k;
      case ($urandom_range(0, 3))
        0: a = IFA;
        1: a = IEA;
        2: a = 16'hff10;
        default: a = 16'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0: k = 8'h01 << $urandom_range(0, 7);
        1: k = 8'($urandom);
        default: k = 8'h00;
      endcase
      step($urandom_range(0, 49) == 0, 5'($urandom), a, 8'($urandom),
           $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, k, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
